// File: rtl/alu_rs_8bit_if.sv
// Dispatch, CDB and issue signals of the add/sub reservation station.
// master: the cluster side (dispatch + CDB source, adder as issue sink).
// slave:  the reservation station itself.
interface alu_rs_8bit_if #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 8
);
    logic              disp_valid;
    logic              disp_ready;
    logic              disp_add_sub;
    logic              disp_carry_in;
    logic              disp_src1_rdy;
    logic [DATA_W-1:0] disp_src1_val;
    logic [TAG_W-1:0]  disp_src1_tag;
    logic              disp_src2_rdy;
    logic [DATA_W-1:0] disp_src2_val;
    logic [TAG_W-1:0]  disp_src2_tag;
    logic [TAG_W-1:0]  disp_dst_tag;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    logic              iss_valid;
    logic              iss_ready;
    logic [DATA_W-1:0] iss_in1;
    logic [DATA_W-1:0] iss_in2;
    logic              iss_add_sub;
    logic              iss_carry_in;
    logic [TAG_W-1:0]  iss_dst_tag;

    modport master (
        output disp_valid, disp_add_sub, disp_carry_in,
               disp_src1_rdy, disp_src1_val, disp_src1_tag,
               disp_src2_rdy, disp_src2_val, disp_src2_tag, disp_dst_tag,
               cdb_valid, cdb_tag, cdb_data, iss_ready,
        input  disp_ready, iss_valid, iss_in1, iss_in2,
               iss_add_sub, iss_carry_in, iss_dst_tag
    );

    modport slave (
        input  disp_valid, disp_add_sub, disp_carry_in,
               disp_src1_rdy, disp_src1_val, disp_src1_tag,
               disp_src2_rdy, disp_src2_val, disp_src2_tag, disp_dst_tag,
               cdb_valid, cdb_tag, cdb_data, iss_ready,
        output disp_ready, iss_valid, iss_in1, iss_in2,
               iss_add_sub, iss_carry_in, iss_dst_tag
    );
endinterface

// File: rtl/alu_rs_8bit.sv
// Age-ordered reservation station feeding the 8-bit adder/subtractor.
// Entries form a compacting queue (index 0 oldest); pending operands are
// captured from the CDB, and the oldest fully-ready entry is moved into a
// registered valid/ready issue stage.
module alu_rs_8bit #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    alu_rs_8bit_if.slave               rs,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic              add_sub;
        logic              carry_in;
        logic              s1_rdy;
        logic [DATA_W-1:0] s1_val;
        logic [TAG_W-1:0]  s1_tag;
        logic              s2_rdy;
        logic [DATA_W-1:0] s2_val;
        logic [TAG_W-1:0]  s2_tag;
        logic [TAG_W-1:0]  dst_tag;
    } entry_t;

    // Capture a CDB broadcast into any still-pending source with a matching tag.
    function automatic entry_t wake(input entry_t e, input logic v,
                                    input logic [TAG_W-1:0] t,
                                    input logic [DATA_W-1:0] d);
        entry_t r;
        r = e;
        if (v && !e.s1_rdy && (e.s1_tag == t)) begin
            r.s1_rdy = 1'b1;
            r.s1_val = d;
        end
        if (v && !e.s2_rdy && (e.s2_tag == t)) begin
            r.s2_rdy = 1'b1;
            r.s2_val = d;
        end
        return r;
    endfunction

    entry_t            ent_q    [DEPTH];
    entry_t            ent_woke [DEPTH];
    entry_t            ent_d    [DEPTH];
    entry_t            new_ent;
    entry_t            sel_ent;
    logic              sel_found;
    logic [CNT_W-1:0]  sel_idx;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  wr_idx;
    logic              disp_fire;
    logic              iss_adv;
    logic              iss_load;

    logic              iss_vld_p0;
    logic [DATA_W-1:0] iss_in1_p0;
    logic [DATA_W-1:0] iss_in2_p0;
    logic              iss_as_p0;
    logic              iss_cin_p0;
    logic [TAG_W-1:0]  iss_dst_p0;

    assign rs.disp_ready = (cnt_q < DEPTH_C);
    assign disp_fire     = rs.disp_valid && rs.disp_ready;
    assign iss_adv       = !iss_vld_p0 || rs.iss_ready;
    assign iss_load      = iss_adv && sel_found;
    assign occupancy     = cnt_q;

    // Oldest valid entry whose two sources are both ready (registered state only).
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_ent   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((CNT_W'(i) < cnt_q) && ent_q[i].s1_rdy && ent_q[i].s2_rdy) begin
                sel_found = 1'b1;
                sel_idx   = CNT_W'(i);
                sel_ent   = ent_q[i];
            end
        end
    end

    // Next queue contents: wakeup, compaction past the issued slot, then append.
    always_comb begin
        new_ent.add_sub  = rs.disp_add_sub;
        new_ent.carry_in = rs.disp_carry_in;
        new_ent.s1_rdy   = rs.disp_src1_rdy;
        new_ent.s1_val   = rs.disp_src1_val;
        new_ent.s1_tag   = rs.disp_src1_tag;
        new_ent.s2_rdy   = rs.disp_src2_rdy;
        new_ent.s2_val   = rs.disp_src2_val;
        new_ent.s2_tag   = rs.disp_src2_tag;
        new_ent.dst_tag  = rs.disp_dst_tag;
        new_ent = wake(new_ent, rs.cdb_valid, rs.cdb_tag, rs.cdb_data);

        for (int i = 0; i < DEPTH; i++) begin
            ent_woke[i] = wake(ent_q[i], rs.cdb_valid && (CNT_W'(i) < cnt_q),
                               rs.cdb_tag, rs.cdb_data);
            ent_d[i]    = ent_woke[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (iss_load && (CNT_W'(i) >= sel_idx)) begin
                ent_d[i] = ent_woke[i+1];
            end
        end
        wr_idx = cnt_q - CNT_W'(iss_load);
        for (int i = 0; i < DEPTH; i++) begin
            if (disp_fire && (CNT_W'(i) == wr_idx)) begin
                ent_d[i] = new_ent;
            end
        end
        cnt_d = cnt_q + CNT_W'(disp_fire) - CNT_W'(iss_load);
    end

    // Entry payload storage; validity is carried entirely by cnt_q.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    // Control state: occupancy count and issue-stage valid.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            cnt_q      <= '0;
            iss_vld_p0 <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (iss_adv) begin
                iss_vld_p0 <= sel_found;
            end
        end
    end

    // ---- issue stage p0: operands held while the adder stalls ----
    // Issue payload register, cleared alongside control so the adder sees zeros.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            iss_in1_p0 <= '0;
            iss_in2_p0 <= '0;
            iss_as_p0  <= 1'b0;
            iss_cin_p0 <= 1'b0;
            iss_dst_p0 <= '0;
        end else if (iss_load) begin
            iss_in1_p0 <= sel_ent.s1_val;
            iss_in2_p0 <= sel_ent.s2_val;
            iss_as_p0  <= sel_ent.add_sub;
            iss_cin_p0 <= sel_ent.carry_in;
            iss_dst_p0 <= sel_ent.dst_tag;
        end
    end

    assign rs.iss_valid    = iss_vld_p0;
    assign rs.iss_in1      = iss_in1_p0;
    assign rs.iss_in2      = iss_in2_p0;
    assign rs.iss_add_sub  = iss_as_p0;
    assign rs.iss_carry_in = iss_cin_p0;
    assign rs.iss_dst_tag  = iss_dst_p0;
endmodule

// File: tb/tb_alu_rs_8bit.sv
// Scoreboard bench for alu_rs_8bit: the stimulus process queues the ops it
// expects to issue, the monitor pops and compares on every accepted issue.
module tb_alu_rs_8bit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [2:0] occupancy;
    int         n_checks = 0;
    int         n_fail   = 0;

    typedef struct {
        logic [7:0] in1;
        logic [7:0] in2;
        logic       as;
        logic       cin;
        logic [3:0] dst;
    } exp_t;
    exp_t exp_q[$];

    alu_rs_8bit_if #(.TAG_W(4), .DATA_W(8)) bus ();

    alu_rs_8bit #(.DEPTH(4), .TAG_W(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .rs        (bus),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.disp_valid = 1'b0;
        bus.cdb_valid  = 1'b0;
    endtask

    task automatic disp(input logic as, input logic cin,
                        input logic r1, input logic [7:0] v1, input logic [3:0] t1,
                        input logic r2, input logic [7:0] v2, input logic [3:0] t2,
                        input logic [3:0] dst);
        bus.disp_valid    = 1'b1;
        bus.disp_add_sub  = as;
        bus.disp_carry_in = cin;
        bus.disp_src1_rdy = r1;
        bus.disp_src1_val = v1;
        bus.disp_src1_tag = t1;
        bus.disp_src2_rdy = r2;
        bus.disp_src2_val = v2;
        bus.disp_src2_tag = t2;
        bus.disp_dst_tag  = dst;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [7:0] d);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = t;
        bus.cdb_data  = d;
    endtask

    task automatic push(input logic [7:0] in1, input logic [7:0] in2,
                        input logic as, input logic cin, input logic [3:0] dst);
        exp_t e;
        e.in1 = in1; e.in2 = in2; e.as = as; e.cin = cin; e.dst = dst;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted issue must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.iss_valid === 1'b1 && bus.iss_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_issue: got in1=0x%0h dst=0x%0h, required no issue",
                         bus.iss_in1, bus.iss_dst_tag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_in1",     32'(bus.iss_in1),      32'(e.in1));
                chk("sb_in2",     32'(bus.iss_in2),      32'(e.in2));
                chk("sb_add_sub", 32'(bus.iss_add_sub),  32'(e.as));
                chk("sb_cin",     32'(bus.iss_carry_in), 32'(e.cin));
                chk("sb_dst",     32'(bus.iss_dst_tag),  32'(e.dst));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        bus.iss_ready = 1'b1;
        bus.disp_add_sub = 0; bus.disp_carry_in = 0;
        bus.disp_src1_rdy = 0; bus.disp_src1_val = 0; bus.disp_src1_tag = 0;
        bus.disp_src2_rdy = 0; bus.disp_src2_val = 0; bus.disp_src2_tag = 0;
        bus.disp_dst_tag = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
        idle();
        cyc();
        cyc();
        // Reset state
        chk("rst_iss_valid",  32'(bus.iss_valid),  0);
        chk("rst_occupancy",  32'(occupancy),      0);
        chk("rst_disp_ready", 32'(bus.disp_ready), 1);
        chk("rst_iss_in1",    32'(bus.iss_in1),    0);
        rst_n = 1'b1;
        cyc();

        // 1: simple add, both ready -> issue two cycles later
        disp(0, 0, 1, 8'h3C, 0, 1, 8'h05, 0, 4'h2);
        push(8'h3C, 8'h05, 0, 0, 4'h2);
        cyc(); idle();
        chk("t1_n1_valid", 32'(bus.iss_valid), 0);
        chk("t1_n1_occ",   32'(occupancy),     1);
        cyc();
        chk("t1_n2_valid", 32'(bus.iss_valid), 1);
        chk("t1_n2_occ",   32'(occupancy),     0);
        cyc();
        chk("t1_n3_valid", 32'(bus.iss_valid), 0);

        // 2: sub with src2 pending on tag 5; tag 6 must not wake it
        disp(1, 0, 1, 8'h20, 0, 0, 8'h00, 4'h5, 4'h7);
        cyc(); idle();
        cdb(4'h6, 8'hAA);
        cyc(); idle(); cyc(); cyc();
        chk("t2_nowake_valid", 32'(bus.iss_valid), 0);
        chk("t2_nowake_occ",   32'(occupancy),     1);
        cdb(4'h5, 8'h11);
        push(8'h20, 8'h11, 1, 0, 4'h7);
        cyc(); idle();
        chk("t2_m1_valid", 32'(bus.iss_valid), 0);
        cyc();
        chk("t2_m2_valid", 32'(bus.iss_valid), 1);
        cyc();

        // 3: same-cycle CDB bypass into a dispatching op
        disp(0, 1, 0, 8'h00, 4'h3, 1, 8'h40, 0, 4'hA);
        cdb(4'h3, 8'h7F);
        push(8'h7F, 8'h40, 0, 1, 4'hA);
        cyc(); idle();
        chk("t3_n1_valid", 32'(bus.iss_valid), 0);
        cyc();
        chk("t3_n2_valid", 32'(bus.iss_valid), 1);
        chk("t3_n2_in1",   32'(bus.iss_in1),   32'h7F);
        cyc();

        // 4: fill all four entries pending on tag 9, then a refused 5th dispatch
        for (int k = 0; k < 4; k++) begin
            disp(k[0], k[1], 0, 8'h00, 4'h9, 1, 8'(8'h10 + k), 0, 4'(8 + k));
            cyc();
        end
        idle();
        chk("t4_full_ready", 32'(bus.disp_ready), 0);
        chk("t4_full_occ",   32'(occupancy),      4);
        disp(0, 0, 1, 8'hEE, 0, 1, 8'hEE, 0, 4'hF);
        cyc(); idle();
        chk("t4_5th_occ",   32'(occupancy),     4);
        chk("t4_5th_valid", 32'(bus.iss_valid), 0);
        cdb(4'h9, 8'h01);
        for (int k = 0; k < 4; k++) push(8'h01, 8'(8'h10 + k), k[0], k[1], 4'(8 + k));
        cyc(); idle();
        chk("t4_m1_valid", 32'(bus.iss_valid), 0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t4_order_valid", 32'(bus.iss_valid),   1);
            chk("t4_order_dst",   32'(bus.iss_dst_tag), 32'(8 + k));
        end
        cyc();
        chk("t4_drain_valid", 32'(bus.iss_valid), 0);
        chk("t4_drain_occ",   32'(occupancy),     0);

        // 5: back-pressure holds A stable; B follows once A is taken
        bus.iss_ready = 1'b0;
        disp(0, 0, 1, 8'hA1, 0, 1, 8'hB1, 0, 4'h3);
        push(8'hA1, 8'hB1, 0, 0, 4'h3);
        cyc();
        disp(1, 1, 1, 8'hA2, 0, 1, 8'hB2, 0, 4'h4);
        push(8'hA2, 8'hB2, 1, 1, 4'h4);
        cyc(); idle();
        for (int k = 0; k < 3; k++) begin
            chk("t5_hold_valid", 32'(bus.iss_valid),   1);
            chk("t5_hold_in1",   32'(bus.iss_in1),     32'hA1);
            chk("t5_hold_in2",   32'(bus.iss_in2),     32'hB1);
            chk("t5_hold_dst",   32'(bus.iss_dst_tag), 3);
            chk("t5_hold_occ",   32'(occupancy),       1);
            if (k < 2) cyc();
        end
        cyc();
        bus.iss_ready = 1'b1;
        chk("t5_a_in1", 32'(bus.iss_in1), 32'hA1);
        cyc();
        chk("t5_b_valid", 32'(bus.iss_valid), 1);
        chk("t5_b_in1",   32'(bus.iss_in1),   32'hA2);
        cyc();
        chk("t5_end_valid", 32'(bus.iss_valid), 0);

        // 6: flush with three entries queued and an op stalled in issue
        bus.iss_ready = 1'b0;
        disp(0, 0, 1, 8'h55, 0, 1, 8'h66, 0, 4'h1);
        cyc();
        for (int k = 0; k < 3; k++) begin
            disp(0, 0, 0, 8'h00, 4'hC, 1, 8'h01, 0, 4'(5 + k));
            cyc();
        end
        idle();
        chk("t6_pre_occ",   32'(occupancy),     3);
        chk("t6_pre_valid", 32'(bus.iss_valid), 1);
        flush = 1'b1;
        disp(0, 0, 1, 8'h77, 0, 1, 8'h88, 0, 4'hE);
        cdb(4'hC, 8'h99);
        cyc();
        flush = 1'b0; idle();
        chk("t6_flush_valid", 32'(bus.iss_valid),  0);
        chk("t6_flush_occ",   32'(occupancy),      0);
        chk("t6_flush_ready", 32'(bus.disp_ready), 1);
        chk("t6_flush_in1",   32'(bus.iss_in1),    0);
        bus.iss_ready = 1'b1;
        cdb(4'hC, 8'h99);
        cyc(); idle(); cyc(); cyc();
        chk("t6_after_valid", 32'(bus.iss_valid), 0);
        chk("t6_after_occ",   32'(occupancy),     0);

        // 7: reset asserted in the middle of a wakeup
        bus.iss_ready = 1'b0;
        disp(1, 1, 1, 8'h5A, 0, 1, 8'hA5, 0, 4'h2);
        cyc();
        for (int k = 0; k < 3; k++) begin
            disp(0, 0, 0, 8'h00, 4'hD, 1, 8'h02, 0, 4'(9 + k));
            cyc();
        end
        idle();
        chk("t7_pre_occ",   32'(occupancy),     3);
        chk("t7_pre_valid", 32'(bus.iss_valid), 1);
        rst_n = 1'b0;
        disp(0, 0, 1, 8'h12, 0, 1, 8'h34, 0, 4'hB);
        cdb(4'hD, 8'h44);
        cyc();
        rst_n = 1'b1; idle();
        chk("t7_rst_valid", 32'(bus.iss_valid),   0);
        chk("t7_rst_occ",   32'(occupancy),       0);
        chk("t7_rst_ready", 32'(bus.disp_ready),  1);
        chk("t7_rst_in1",   32'(bus.iss_in1),     0);
        chk("t7_rst_dst",   32'(bus.iss_dst_tag), 0);
        bus.iss_ready = 1'b1;
        cdb(4'hD, 8'h44);
        cyc(); idle(); cyc(); cyc();
        chk("t7_after_valid", 32'(bus.iss_valid), 0);

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_rs_8bit.md
Name: alu_rs_8bit

Overview:
- Four-entry reservation station directly upstream of the 8-bit adder/subtractor in the OoO execution cluster.
- Accepts dispatched add/sub micro-ops whose operands may still be pending.
- Snoops the common data bus (CDB) to capture pending operands.
- Issues the oldest fully-ready op through a registered valid/ready port that drives the adder's in1, in2, add_sub and carry_in.

Parameters:
- DEPTH, 4, number of station entries (power of two, 2..8).
- TAG_W, 4, physical-register / ROB tag width.
- DATA_W, 8, operand width; matches the adder width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  synchronous clear of all state (mispredict)
- disp_valid  in  1  dispatch request
- disp_ready  out  1  at least one free entry
- disp_add_sub  in  1  0=add, 1=subtract
- disp_carry_in  in  1  carry into bit 0
- disp_src1_rdy  in  1  src1 value valid
- disp_src1_val  in  DATA_W  src1 value
- disp_src1_tag  in  TAG_W  src1 producer tag
- disp_src2_rdy  in  1  src2 value valid
- disp_src2_val  in  DATA_W  src2 value
- disp_src2_tag  in  TAG_W  src2 producer tag
- disp_dst_tag  in  TAG_W  result tag
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  CDB tag
- cdb_data  in  DATA_W  CDB value
- iss_valid  out  1  issue register holds an op
- iss_ready  in  1  adder stage accepts
- iss_in1  out  DATA_W  operand 1 to adder
- iss_in2  out  DATA_W  operand 2 to adder (un-inverted; adder applies add_sub)
- iss_add_sub  out  1  op select
- iss_carry_in  out  1  carry in
- iss_dst_tag  out  TAG_W  result tag
- occupancy  out  $clog2(DEPTH+1)  valid entry count

Behaviour:
- Reset (rst_n=0 at an edge): all entry valids 0, iss_valid 0, iss_* data 0, occupancy 0, disp_ready 1. Reset overrides flush, dispatch and CDB.
- flush=1 at an edge: same clearing as reset. Dispatch and CDB in that cycle are discarded.
- disp_ready = (occupancy < DEPTH), computed from registered state only. A slot freed by issue in the same cycle is not visible until the next cycle.
- Dispatch fires on disp_valid && disp_ready. Entry is written at the edge with source ready bits and values as presented.
- Same-cycle bypass: if a dispatched source is not ready, cdb_valid=1 and cdb_tag matches its tag, the entry stores cdb_data with that source marked ready.
- Wakeup: at each edge with cdb_valid=1, every valid entry source with rdy=0 and a matching tag captures cdb_data and sets rdy=1.
  - Both sources may match in one edge.
  - Non-matching tags have no effect.
- Entries are held in age order as a compacting queue; index 0 is the oldest.
- Selection is combinational: the lowest-index entry with both sources ready, using registered entry state.
  - A source woken at edge N becomes selectable in cycle N+1.
- The issue register loads when (!iss_valid || iss_ready) and a selection exists.
  - The selected entry is removed at the same edge and younger entries shift down.
  - Dispatch in the same cycle appends after the compaction.
- If iss_valid && !iss_ready, all iss_* outputs hold stable and no entry is removed.
- If iss_ready=1 and nothing is selected, iss_valid drops to 0 at the edge.
- Latency: dispatch with both sources ready in cycle N gives iss_valid in cycle N+2 at the earliest. A CDB wakeup in cycle N gives iss_valid in cycle N+2 at the earliest.
- Throughput: one issue per cycle when iss_ready stays high.
- occupancy = number of valid entries. It updates by +1 on dispatch, -1 on removal, and is unchanged when both happen.
- No arithmetic is performed here. Operands pass unmodified and widths are exact (DATA_W).

Test Plan:
- Reset, then dispatch add 0x3C,0x05, cin=0, dst=2, both ready, at cycle N -> iss_valid=1 at N+2 with in1=0x3C, in2=0x05, add_sub=0, dst_tag=2; occupancy 1 then 0.
- Dispatch sub, src1=0x20 ready, src2 pending tag 5, dst=7. CDB tag 6 data 0xAA -> no issue. CDB tag 5 data 0x11 -> iss_valid 2 cycles later with in1=0x20, in2=0x11, add_sub=1.
- Dispatch src1 pending tag 3 while cdb_valid=1, tag=3, data=0x7F in the same cycle -> entry captures 0x7F and issues at N+2.
- Four dispatches, all pending tag 9 -> disp_ready=0, occupancy=4, 5th dispatch ignored. CDB tag 9 data 0x01 -> all four issue in dispatch order on four consecutive cycles with iss_ready=1.
- Two ready ops A then B with iss_ready=0 for 3 cycles -> A's outputs held stable; on iss_ready=1, A accepted, then B next cycle.
- Flush with 3 entries and iss_valid=1 -> next cycle iss_valid=0, occupancy=0, disp_ready=1. Repeat with rst_n=0 mid-wakeup -> same result.
